// File: rtl/l2_interco_pkg.sv
// Shared L2 interconnect types: default geometry, master ID type and request payload.
package l2_interco_pkg;

  localparam int unsigned L2_N_MASTER        = 4;
  localparam int unsigned L2_ADDR_WIDTH      = 12;
  localparam int unsigned L2_DATA_WIDTH      = 64;
  localparam int unsigned L2_BE_WIDTH        = L2_DATA_WIDTH / 8;
  localparam int unsigned L2_MAX_OUTSTANDING = 4;
  localparam int unsigned L2_ID_WIDTH        = $clog2(L2_N_MASTER);

  typedef logic [L2_ID_WIDTH-1:0] mid_t;

  typedef struct packed {
    logic [L2_ADDR_WIDTH-1:0] add;
    logic                     wen;
    logic [L2_DATA_WIDTH-1:0] wdata;
    logic [L2_BE_WIDTH-1:0]   be;
  } l2_req_t;

endpackage

// File: rtl/request_arb_l2_if.sv
// Master-side and slave-side request/response bundle of one L2 slave port arbiter.
interface request_arb_l2_if import l2_interco_pkg::*; #(
  parameter int unsigned N_MASTER   = L2_N_MASTER,
  parameter int unsigned ADDR_WIDTH = L2_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = L2_DATA_WIDTH,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) ();

  logic [N_MASTER-1:0]                 data_req_i;
  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
  logic [N_MASTER-1:0]                 data_wen_i;
  logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i;
  logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i;
  logic [N_MASTER-1:0]                 data_gnt_o;
  logic [N_MASTER-1:0]                 data_r_valid_o;
  logic [DATA_WIDTH-1:0]               data_r_rdata_o;

  logic                  data_req_o;
  logic [ADDR_WIDTH-1:0] data_add_o;
  logic                  data_wen_o;
  logic [DATA_WIDTH-1:0] data_wdata_o;
  logic [BE_WIDTH-1:0]   data_be_o;
  logic                  data_gnt_i;
  logic                  data_r_valid_i;
  logic [DATA_WIDTH-1:0] data_r_rdata_i;

  // Arbiter view: slave towards the masters, master towards the memory port.
  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
    input  data_gnt_i, data_r_valid_i, data_r_rdata_i,
    output data_gnt_o, data_r_valid_o, data_r_rdata_o,
    output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
    output data_gnt_i, data_r_valid_i, data_r_rdata_i,
    input  data_gnt_o, data_r_valid_o, data_r_rdata_o,
    input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o
  );

endinterface

// File: rtl/id_fifo_l2.sv
// In-order FIFO of master IDs for accepted L2 transactions; push/pop are ignored when full/empty.
module id_fifo_l2 #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  logic [IDW-1:0] id_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output logic [IDW-1:0] head_o
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  logic [IDW-1:0]  mem_q [DEPTH];
  logic [PTRW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= id_i;
  end

endmodule

// File: rtl/request_arb_l2.sv
// Round-robin request arbiter for one L2 slave port with in-order response steering.
// Define REQ_ARB_L2_STICKY_EN to keep a stalled winner locked until its handshake.
module request_arb_l2 import l2_interco_pkg::*; #(
  parameter int unsigned N_MASTER        = L2_N_MASTER,
  parameter int unsigned ADDR_WIDTH      = L2_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = L2_DATA_WIDTH,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = L2_MAX_OUTSTANDING
) (
  input logic             clk,
  input logic             rst,
  request_arb_l2_if.slave bus
);

  localparam int unsigned IDW = $clog2(N_MASTER);

  logic [IDW-1:0] rr_q, rr_d, winner, cand, head_id;
  logic           any_req, fifo_full, fifo_empty, handshake;
  l2_req_t        win_req;

`ifdef REQ_ARB_L2_STICKY_EN
  logic [IDW-1:0] lock_q, lock_d;
  logic           lock_v_q, lock_v_d;
`endif

  always_comb begin
    winner  = rr_q;
    any_req = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N_MASTER; k++) begin
      cand = IDW'((32'(rr_q) + k) % N_MASTER);
      if (!any_req && bus.data_req_i[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
`ifdef REQ_ARB_L2_STICKY_EN
    // A locked master that still requests overrides the round-robin pick.
    if (lock_v_q && bus.data_req_i[lock_q]) winner = lock_q;
`endif
  end

  assign win_req = '{add:   bus.data_add_i[winner],
                     wen:   bus.data_wen_i[winner],
                     wdata: bus.data_wdata_i[winner],
                     be:    bus.data_be_i[winner]};

  assign handshake = bus.data_req_o & bus.data_gnt_i;

  always_comb begin
    bus.data_req_o     = any_req & ~fifo_full;
    bus.data_add_o     = win_req.add;
    bus.data_wen_o     = win_req.wen;
    bus.data_wdata_o   = win_req.wdata;
    bus.data_be_o      = win_req.be;
    bus.data_r_rdata_o = bus.data_r_rdata_i;
    bus.data_gnt_o     = '0;
    bus.data_r_valid_o = '0;
    if (handshake) bus.data_gnt_o[winner] = 1'b1;
    if (bus.data_r_valid_i && !fifo_empty) bus.data_r_valid_o[head_id] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (handshake) rr_d = IDW'((32'(winner) + 32'd1) % N_MASTER);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

`ifdef REQ_ARB_L2_STICKY_EN
  always_comb begin
    lock_d   = lock_q;
    lock_v_d = lock_v_q;
    if (handshake) begin
      lock_v_d = 1'b0;
    end else if (bus.data_req_o && !bus.data_gnt_i) begin
      lock_d   = winner;
      lock_v_d = 1'b1;
    end else if (lock_v_q && !bus.data_req_i[lock_q]) begin
      lock_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q   <= '0;
      lock_v_q <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      lock_v_q <= lock_v_d;
    end
  end
`endif

  id_fifo_l2 #(
    .DEPTH (MAX_OUTSTANDING),
    .IDW   (IDW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (handshake),
    .id_i    (winner),
    .pop_i   (bus.data_r_valid_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_id)
  );

endmodule
